ctrl_mc: RTL and testbench
==========================

CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: opcode  in  6  instr[31:26] from IR; funct  in  6  instr[5:0] from IR.
REQ-004 SHALL have ports: mem_ready  in  1  memory access complete this cycle; zero  in  1  ALU zero flag.
REQ-005 SHALL have ports: pc_write  out  1  PC load enable (includes branch decision); iord  out  1  0=PC, 1=ALUOut address.
REQ-006 SHALL have ports: mem_read  out  1; mem_write  out  1; ir_write  out  1  IR load enable.
REQ-007 SHALL have ports: reg_dst  out  1  1=rd, 0=rt; mem_to_reg  out  1  1=MDR; reg_write  out  1.
REQ-008 SHALL have ports: alu_src_a  out  1  0=PC, 1=reg A; alu_src_b  out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2.
REQ-009 SHALL have ports: alu_op  out  2  00=ADD, 01=SUB, 10=decode funct (to ALU-control decoder); pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=reg A.
REQ-010 SHALL have ports: state  out  4  current state (debug); illegal  out  1  sticky unsupported-opcode flag.

Function
REQ-011 SHALL implement FSM states/encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, ADDI_EX 9, ADDI_WB 10, JUMP 11, JR 12, TRAP 13; codes 14-15 -> FETCH next cycle.
REQ-012 SHALL drive every output 0 unless asserted below for the current state.
REQ-013 FETCH SHALL assert mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write only when mem_ready=1; hold FETCH while mem_ready=0, else -> DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute) and go: 000000 with funct 001000 -> JR; other 000000 -> R_EXEC; 100011/101011 -> MEM_ADR; 000100/000101 -> BRANCH; 001000 -> ADDI_EX; 000010 -> JUMP; anything else -> TRAP.
REQ-015 MEM_ADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; -> MEM_RD if opcode 100011, else MEM_WR.
REQ-016 MEM_RD SHALL assert mem_read, iord=1; hold while mem_ready=0; -> MEM_WB on mem_ready=1.
REQ-017 MEM_WB SHALL assert reg_write, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-018 MEM_WR SHALL assert mem_write, iord=1; hold while mem_ready=0; -> FETCH on mem_ready=1.
REQ-019 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB. R_WB SHALL assert reg_write, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-020 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write=zero for 000100, pc_write=~zero for 000101; -> FETCH.
REQ-021 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; -> ADDI_WB, which asserts reg_write, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-022 JUMP SHALL assert pc_write, pc_source=10; JR SHALL assert pc_write, pc_source=11; both -> FETCH.
REQ-023 TRAP SHALL set illegal=1, assert no write enables, and remain until reset.
REQ-024 Latency with mem_ready tied 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, jr 3 cycles.
REQ-025 Each mem_ready wait cycle SHALL add exactly one cycle; opcode/funct SHALL be sampled only in DECODE and MEM_ADR (IR stable).
REQ-026 Outputs SHALL be Moore from state except pc_write/ir_write (gated by mem_ready, zero) and opcode-dependent branch polarity.

Reset
REQ-027 rst_n=0 SHALL immediately force state=FETCH, illegal=0, all write enables and mem_read/mem_write 0 asynchronously.
REQ-028 Reset asserted mid-wait (MEM_RD/MEM_WR/FETCH) SHALL abort the access; after release, FETCH restarts with no residual write.

Structure
REQ-029 Package ctrl_pkg SHALL hold opcode/funct constants, state encoding, and alu_op, alu_src_b, pc_source encodings.
REQ-030 Single module, no sub-module; alu_op feeds the existing ALU-control decoder outside this block.

Verification
REQ-031 R-type add (000000/100000), mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in R_EXEC; reg_write=1, reg_dst=1 in R_WB.
REQ-032 lw with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; mem_read,iord=1 held; exactly one reg_write pulse, mem_to_reg=1.
REQ-033 beq zero=1 -> pc_write=1, pc_source=01 in BRANCH; bne zero=1 -> pc_write=0; both return to FETCH.
REQ-034 opcode 111111 -> TRAP, illegal=1 stays with no enables for 20 cycles; rst_n pulse -> state=0, illegal=0.
REQ-035 rst_n low during MEM_WR wait -> mem_write drops same cycle; after release state=FETCH, no mem_write until next sw.
REQ-036 jr (funct 001000) -> states 0,1,12,0; pc_source=11, pc_write=1 in JR.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: instruction
// fields, FSM state codes and the datapath mux/ALU select values.
package ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11,
        S_JR      = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_REGA   = 2'b11
    } pc_source_t;

    // Dispatch target out of DECODE for a given opcode/funct pair.
    function automatic state_t decode_dispatch(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        case (op)
            OP_RTYPE:     nxt = (fn == FN_JR) ? S_JR : S_R_EXEC;
            OP_LW, OP_SW: nxt = S_MEM_ADR;
            OP_BEQ,
            OP_BNE:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDI_EX;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_mc.sv
// Multi-cycle controller: one Moore FSM sequencing fetch, decode, memory,
// ALU, branch and jump phases. Only pc_write/ir_write look at mem_ready/zero.
module ctrl_mc
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    state_t cur_state;
    state_t nxt_state;
    logic   branch_ne;

    logic   pc_write_raw;
    logic   ir_write_raw;
    logic   mem_read_raw;
    logic   mem_write_raw;
    logic   reg_write_raw;

    assign state = cur_state;

    // Next-state selection; IR fields are only consulted in DECODE and MEM_ADR.
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:   nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  nxt_state = decode_dispatch(opcode, funct);
            S_MEM_ADR: nxt_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  nxt_state = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  nxt_state = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:  nxt_state = S_R_WB;
            S_ADDI_EX: nxt_state = S_ADDI_WB;
            S_TRAP:    nxt_state = S_TRAP;
            S_MEM_WB, S_R_WB, S_BRANCH,
            S_ADDI_WB, S_JUMP, S_JR:
                       nxt_state = S_FETCH;
            default:   nxt_state = S_FETCH;
        endcase
    end

    // State register, sticky illegal flag and branch polarity captured at DECODE.
    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            illegal   <= 1'b0;
            branch_ne <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                branch_ne <= (opcode == OP_BNE);
            end
            if (nxt_state == S_TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    // Moore output decode; pc_write/ir_write additionally gated by mem_ready/zero.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        iord          = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        case (cur_state)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEM_ADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                pc_source    = PCSRC_ALUOUT;
                pc_write_raw = branch_ne ? ~zero : zero;
            end
            S_ADDI_WB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                pc_source    = PCSRC_JUMP;
            end
            S_JR: begin
                pc_write_raw = 1'b1;
                pc_source    = PCSRC_REGA;
            end
            default: ;
        endcase
    end

    // Strobes are masked by rst_n directly so an in-flight access dies the
    // instant reset asserts, not at the next clock edge.
    assign pc_write  = pc_write_raw  & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign mem_read  = mem_read_raw  & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign reg_write = reg_write_raw & rst_n;

endmodule

// File: tb/tb_ctrl_mc.sv
// Bench for ctrl_mc: an instruction-level model expands each instruction into
// its expected per-cycle control words; a compare process checks every cycle.
module tb_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    ctrl_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ill, pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb, aop, pcs;
    } cw_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000;

    cw_t        exp_q[$];
    cw_t        cmp_e;
    int         vectors = 0;
    int         miscompares = 0;
    bit         model_ill = 1'b0;
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_fn = 6'd0;
    bit         cur_z = 1'b0;
    int         regw_cnt = 0;
    int         memw_cnt = 0;
    int         wen_cnt = 0;
    wire  [19:0] act_w = {state, illegal, pc_write, iord, mem_read, mem_write, ir_write,
                          reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model's expected control word.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            check("cycle", act_w, cmp_e);
        end
    end

    // Strobe activity counters; the driver reads deltas across an instruction.
    always @(negedge clk) begin
        if (reg_write === 1'b1) regw_cnt++;
        if (mem_write === 1'b1) memw_cnt++;
        if ((pc_write | ir_write | reg_write | mem_write) === 1'b1) wen_cnt++;
    end

    function automatic cw_t base(input logic [3:0] st);
        cw_t c = '0;
        c.st  = st;
        c.ill = model_ill;
        return c;
    endfunction

    function automatic cw_t rst_word();
        cw_t c = base(4'd0);
        c.srcb = 2'b01;
        return c;
    endfunction

    task automatic step(input bit rdy, input bit rst, input cw_t e);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        rst_n     = rst;
        opcode    = cur_op;
        funct     = cur_fn;
        zero      = cur_z;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle-by-cycle expected control words.
    // dc is the mem_ready value driven in cycles where it must not matter.
    task automatic exec(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit dc,
                        input int fetch_waits, input int mem_waits, output int n);
        cw_t e;
        cur_op = op; cur_fn = fn; cur_z = z; n = 0;
        e = base(4'd0); e.mrd = 1'b1; e.srcb = 2'b01;
        repeat (fetch_waits) begin step(1'b0, 1'b1, e); n++; end
        e.irw = 1'b1; e.pcw = 1'b1;
        step(1'b1, 1'b1, e); n++;
        e = base(4'd1); e.srcb = 2'b11;
        step(dc, 1'b1, e); n++;
        if (op == 6'd0 && fn == FN_JR) begin
            e = base(4'd12); e.pcw = 1'b1; e.pcs = 2'b11; step(dc, 1'b1, e); n++;
        end else if (op == 6'd0) begin
            e = base(4'd6); e.srca = 1'b1; e.aop = 2'b10; step(dc, 1'b1, e); n++;
            e = base(4'd7); e.rw = 1'b1; e.rdst = 1'b1; step(dc, 1'b1, e); n++;
        end else if (op == LW || op == SW) begin
            e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10; step(dc, 1'b1, e); n++;
            if (op == LW) begin
                e = base(4'd3); e.mrd = 1'b1; e.iord = 1'b1;
            end else begin
                e = base(4'd5); e.mwr = 1'b1; e.iord = 1'b1;
            end
            repeat (mem_waits) begin step(1'b0, 1'b1, e); n++; end
            step(1'b1, 1'b1, e); n++;
            if (op == LW) begin
                e = base(4'd4); e.rw = 1'b1; e.m2r = 1'b1; step(dc, 1'b1, e); n++;
            end
        end else if (op == BEQ || op == BNE) begin
            e = base(4'd8); e.srca = 1'b1; e.aop = 2'b01; e.pcs = 2'b01;
            e.pcw = (op == BEQ) ? z : !z;
            step(dc, 1'b1, e); n++;
        end else if (op == ADDI) begin
            e = base(4'd9); e.srca = 1'b1; e.srcb = 2'b10; step(dc, 1'b1, e); n++;
            e = base(4'd10); e.rw = 1'b1; step(dc, 1'b1, e); n++;
        end else if (op == J) begin
            e = base(4'd11); e.pcw = 1'b1; e.pcs = 2'b10; step(dc, 1'b1, e); n++;
        end else begin
            model_ill = 1'b1;
            e = base(4'd13); step(dc, 1'b1, e); n++;
        end
        settle();
    endtask

    initial begin
        int  n;
        int  snap_rw, snap_mw, snap_wen;
        cw_t e;

        // Power-on reset.
        step(1'b1, 1'b0, rst_word());
        step(1'b1, 1'b0, rst_word());
        settle();
        check("reset_state", 20'(state), 20'd0);
        check("reset_illegal", 20'(illegal), 20'd0);
        check("reset_mem_read", 20'(mem_read), 20'd0);

        // Latencies with mem_ready held high.
        snap_rw = regw_cnt;
        exec(6'd0, FN_ADD, 1'b0, 1'b1, 0, 0, n); check("lat_rtype", 20'(n), 20'd4);
        check("rtype_regw", 20'(regw_cnt - snap_rw), 20'd1);
        snap_rw = regw_cnt;
        exec(LW, 6'd0, 1'b0, 1'b1, 0, 0, n);     check("lat_lw", 20'(n), 20'd5);
        check("lw_regw", 20'(regw_cnt - snap_rw), 20'd1);
        snap_mw = memw_cnt;
        exec(SW, 6'd0, 1'b0, 1'b1, 0, 0, n);     check("lat_sw", 20'(n), 20'd4);
        check("sw_memw", 20'(memw_cnt - snap_mw), 20'd1);
        exec(ADDI, 6'd0, 1'b0, 1'b1, 0, 0, n);   check("lat_addi", 20'(n), 20'd4);
        exec(BEQ, 6'd0, 1'b1, 1'b1, 0, 0, n);    check("lat_beq", 20'(n), 20'd3);
        exec(J, 6'd0, 1'b0, 1'b1, 0, 0, n);      check("lat_j", 20'(n), 20'd3);
        exec(6'd0, FN_JR, 1'b0, 1'b1, 0, 0, n);  check("lat_jr", 20'(n), 20'd3);

        // Branch polarity in both directions; mem_ready low where ignored.
        exec(BEQ, 6'd0, 1'b0, 1'b0, 0, 0, n);
        exec(BNE, 6'd0, 1'b1, 1'b0, 0, 0, n);    check("lat_bne", 20'(n), 20'd3);
        exec(BNE, 6'd0, 1'b0, 1'b0, 0, 0, n);

        // Wait states: each low mem_ready cycle adds exactly one cycle.
        snap_rw = regw_cnt;
        exec(LW, 6'd0, 1'b0, 1'b0, 0, 2, n);     check("lat_lw_wait2", 20'(n), 20'd7);
        check("lw_wait_regw", 20'(regw_cnt - snap_rw), 20'd1);
        exec(LW, 6'd0, 1'b0, 1'b1, 1, 1, n);     check("lat_lw_fw1_mw1", 20'(n), 20'd7);
        exec(SW, 6'd0, 1'b0, 1'b0, 2, 3, n);     check("lat_sw_fw2_mw3", 20'(n), 20'd9);
        exec(6'd0, 6'b100010, 1'b1, 1'b0, 0, 0, n);

        // Reset in the middle of a store wait aborts the write at once.
        cur_op = SW; cur_fn = 6'd0; cur_z = 1'b0;
        e = base(4'd0); e.mrd = 1'b1; e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
        step(1'b1, 1'b1, e);
        e = base(4'd1); e.srcb = 2'b11; step(1'b0, 1'b1, e);
        e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10; step(1'b0, 1'b1, e);
        e = base(4'd5); e.mwr = 1'b1; e.iord = 1'b1;
        step(1'b0, 1'b1, e);
        step(1'b0, 1'b1, e);
        model_ill = 1'b0;
        step(1'b0, 1'b0, rst_word());
        #1;
        check("abort_mem_write", 20'(mem_write), 20'd0);
        check("abort_state", 20'(state), 20'd0);
        settle();
        snap_mw = memw_cnt;
        exec(6'd0, FN_ADD, 1'b0, 1'b1, 0, 0, n);
        exec(ADDI, 6'd0, 1'b0, 1'b0, 0, 0, n);
        check("post_abort_memw", 20'(memw_cnt - snap_mw), 20'd0);

        // Unsupported opcode traps and stays trapped with no strobes.
        exec(6'b111111, 6'd0, 1'b0, 1'b1, 0, 0, n);
        snap_wen = wen_cnt;
        e = base(4'd13);
        for (int i = 0; i < 20; i++) begin
            cur_z = i[0];
            step(i[1], 1'b1, e);
        end
        settle();
        check("trap_illegal", 20'(illegal), 20'd1);
        check("trap_state", 20'(state), 20'd13);
        check("trap_no_enables", 20'(wen_cnt - snap_wen), 20'd0);
        model_ill = 1'b0;
        step(1'b0, 1'b0, rst_word());
        #1;
        check("trap_reset_state", 20'(state), 20'd0);
        check("trap_reset_illegal", 20'(illegal), 20'd0);
        settle();
        exec(6'd0, FN_ADD, 1'b0, 1'b1, 0, 0, n);
        check("recover_rtype", 20'(n), 20'd4);

        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
